// File: rtl/hazard_pkg.sv
// Shared constants and scoreboard entry type for the forwarding / hazard unit.
// The entry fields are sized for the largest supported REG_AW / LAT_W; narrower indexes are zero-extended.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int RD_MAX_W  = 8;
  localparam int CNT_MAX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [RD_MAX_W-1:0]  rd;
    logic [CNT_MAX_W-1:0] count;
  } sb_entry_t;

  // One clock of countdown: an entry on its last cycle retires, otherwise it counts down.
  function automatic sb_entry_t sb_tick(input sb_entry_t e);
    sb_entry_t r;
    r = e;
    if (e.valid) begin
      if (e.count == CNT_MAX_W'(1)) r = '0;
      else r.count = e.count - CNT_MAX_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sb_table.sv
// Scoreboard of in-flight long-latency writes: allocation, per-entry countdown and
// per-source match vector against the ID-stage operands.
module sb_table
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int SB_DEPTH = 4,
  parameter int LAT_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [LAT_W-1:0]          issue_lat,
  input  logic [NUM_SRC*REG_AW-1:0] query_rs,
  output logic                      issue_ready,
  output logic                      busy,
  output logic [NUM_SRC-1:0]        match
);

  sb_entry_t            entry_reg  [SB_DEPTH];
  sb_entry_t            entry_next [SB_DEPTH];
  sb_entry_t            new_entry;
  logic [SB_DEPTH-1:0]  valid_vec;
  logic [SB_DEPTH-1:0]  take;
  logic                 accept;
  logic                 found;
  logic [CNT_MAX_W-1:0] lat_eff;

  genvar gi, gs;

  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_valid
      assign valid_vec[gi] = entry_reg[gi].valid;
    end
  endgenerate

  assign issue_ready = ~&valid_vec;
  assign busy        = |valid_vec;
  // Writes to x0 are accepted by the handshake but never occupy an entry.
  assign accept      = issue_valid & issue_ready & (issue_rd != '0);
  assign lat_eff     = (issue_lat == '0) ? CNT_MAX_W'(1) : CNT_MAX_W'(issue_lat);
  assign new_entry   = '{valid: 1'b1, rd: RD_MAX_W'(issue_rd), count: lat_eff};

  // Lowest-index entry that was free before this edge; one retiring now is not reused.
  always_comb begin
    take  = '0;
    found = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (!valid_vec[k] && !found) begin
        take[k] = accept;
        found   = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_next
      assign entry_next[gi] = take[gi] ? new_entry : sb_tick(entry_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SB_DEPTH; k++) entry_reg[k] <= '0;
    end else begin
      for (int k = 0; k < SB_DEPTH; k++) entry_reg[k] <= entry_next[k];
    end
  end

  generate
    for (gs = 0; gs < NUM_SRC; gs++) begin : g_src
      logic [REG_AW-1:0]   src;
      logic [SB_DEPTH-1:0] hit;
      assign src = query_rs[gs*REG_AW +: REG_AW];
      for (gi = 0; gi < SB_DEPTH; gi++) begin : g_ent
        assign hit[gi] = entry_reg[gi].valid && (src != '0) &&
                         (entry_reg[gi].rd == RD_MAX_W'(src));
      end
      assign match[gs] = |hit;
    end
  endgenerate

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, load-use and scoreboard stall detection,
// plus a saturating count of stalled cycles.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int SB_DEPTH = 4,
  parameter int LAT_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      mem_wb_regwrite,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
  input  logic [NUM_SRC*REG_AW-1:0] if_id_rs,
  input  logic                      id_ex_memread,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [LAT_W-1:0]          issue_lat,
  output logic                      issue_ready,
  output logic [2*NUM_SRC-1:0]      forward_sel,
  output logic                      stall,
  output logic                      sb_busy,
  output logic [31:0]               stall_cycles
);

  logic [NUM_SRC-1:0] load_use;
  logic [NUM_SRC-1:0] sb_match;
  logic [31:0]        stall_cycles_reg;
  logic [31:0]        stall_cycles_next;

  genvar gi;

  sb_table #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .SB_DEPTH(SB_DEPTH),
    .LAT_W   (LAT_W)
  ) u_sb_table (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_lat  (issue_lat),
    .query_rs   (if_id_rs),
    .issue_ready(issue_ready),
    .busy       (sb_busy),
    .match      (sb_match)
  );

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] ex_src;
      logic [REG_AW-1:0] id_src;
      logic              hit_mem;
      logic              hit_wb;
      assign ex_src  = id_ex_rs[gi*REG_AW +: REG_AW];
      assign id_src  = if_id_rs[gi*REG_AW +: REG_AW];
      assign hit_mem = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == ex_src);
      assign hit_wb  = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == ex_src);
      // The younger EX/MEM result wins over MEM/WB.
      assign forward_sel[2*gi +: 2] = hit_mem ? FWD_MEM : (hit_wb ? FWD_WB : FWD_NONE);
      assign load_use[gi] = id_ex_memread && (id_ex_rd != '0) && (id_ex_rd == id_src);
    end
  endgenerate

  assign stall = |(load_use | sb_match);

  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    if (stall && (stall_cycles_reg != 32'hFFFF_FFFF))
      stall_cycles_next = stall_cycles_reg + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_reg <= '0;
    else     stall_cycles_reg <= stall_cycles_next;
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an expiry-time scoreboard model.
module tb_fwd_hazard_unit;

  localparam int REG_AW   = 5;
  localparam int NUM_SRC  = 2;
  localparam int SB_DEPTH = 4;
  localparam int LAT_W    = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      ex_mem_regwrite;
  logic [REG_AW-1:0]         ex_mem_rd;
  logic                      mem_wb_regwrite;
  logic [REG_AW-1:0]         mem_wb_rd;
  logic [NUM_SRC*REG_AW-1:0] id_ex_rs;
  logic [NUM_SRC*REG_AW-1:0] if_id_rs;
  logic                      id_ex_memread;
  logic [REG_AW-1:0]         id_ex_rd;
  logic                      issue_valid;
  logic [REG_AW-1:0]         issue_rd;
  logic [LAT_W-1:0]          issue_lat;
  logic                      issue_ready;
  logic [2*NUM_SRC-1:0]      forward_sel;
  logic                      stall;
  logic                      sb_busy;
  logic [31:0]               stall_cycles;

  fwd_hazard_unit #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .SB_DEPTH(SB_DEPTH), .LAT_W(LAT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_mem_regwrite(ex_mem_regwrite),
    .ex_mem_rd      (ex_mem_rd),
    .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_rd      (mem_wb_rd),
    .id_ex_rs       (id_ex_rs),
    .if_id_rs       (if_id_rs),
    .id_ex_memread  (id_ex_memread),
    .id_ex_rd       (id_ex_rd),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_lat      (issue_lat),
    .issue_ready    (issue_ready),
    .forward_sel    (forward_sel),
    .stall          (stall),
    .sb_busy        (sb_busy),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: live writes as (rd, absolute cycle at which they vanish).
  int     m_rd[$];
  longint m_exp[$];
  longint ncyc = 0;
  longint m_stall = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input int i);
    int s;
    s = int'(id_ex_rs[i*REG_AW +: REG_AW]);
    if (ex_mem_regwrite && ex_mem_rd != 0 && int'(ex_mem_rd) == s) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd != 0 && int'(mem_wb_rd) == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_stall();
    int s;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = int'(if_id_rs[i*REG_AW +: REG_AW]);
      if (id_ex_memread && id_ex_rd != 0 && int'(id_ex_rd) == s) return 1'b1;
      if (s != 0) foreach (m_rd[j]) if (m_rd[j] == s) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_all();
    for (int i = 0; i < NUM_SRC; i++)
      chk($sformatf("fwd%0d", i), 64'(forward_sel[2*i +: 2]), 64'(exp_fwd(i)));
    chk("stall", 64'(stall), 64'(exp_stall()));
    chk("issue_ready", 64'(issue_ready), 64'(m_rd.size() < SB_DEPTH));
    chk("sb_busy", 64'(sb_busy), 64'(m_rd.size() != 0));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
  endtask

  task automatic model_reset();
    m_rd.delete();
    m_exp.delete();
    m_stall = 0;
  endtask

  task automatic model_edge();
    bit ready_pre;
    int lat;
    if (rst) begin
      model_reset();
      ncyc++;
      return;
    end
    ready_pre = (m_rd.size() < SB_DEPTH);
    if (exp_stall() && m_stall != 64'hFFFF_FFFF) m_stall++;
    ncyc++;
    if (issue_valid && ready_pre && issue_rd != 0) begin
      lat = (issue_lat == 0) ? 1 : int'(issue_lat);
      m_rd.push_back(int'(issue_rd));
      m_exp.push_back(ncyc + lat);
    end
    for (int j = m_rd.size() - 1; j >= 0; j--) begin
      if (m_exp[j] <= ncyc) begin
        m_rd.delete(j);
        m_exp.delete(j);
      end
    end
  endtask

  // Entered and left just after a falling edge; inputs are already applied.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ex_mem_regwrite = 0; ex_mem_rd = 0; mem_wb_regwrite = 0; mem_wb_rd = 0;
    id_ex_rs = 0; if_id_rs = 0; id_ex_memread = 0; id_ex_rd = 0;
    issue_valid = 0; issue_rd = 0; issue_lat = 0;
    @(negedge clk);
    #1 chk("rst_ready", 64'(issue_ready), 64'd1);
    chk("rst_busy", 64'(sb_busy), 64'd0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Forward priority
    ex_mem_regwrite = 1; ex_mem_rd = 5; mem_wb_regwrite = 1; mem_wb_rd = 5;
    id_ex_rs = {5'd0, 5'd5};
    #1 chk("fwd_prio_mem", 64'(forward_sel[1:0]), 64'h2);
    cycle();
    ex_mem_regwrite = 0;
    #1 chk("fwd_prio_wb", 64'(forward_sel[1:0]), 64'h1);
    cycle();

    // x0 handling
    ex_mem_regwrite = 1; ex_mem_rd = 0; mem_wb_regwrite = 1; mem_wb_rd = 0; id_ex_rs = 0;
    #1 chk("fwd_x0", 64'(forward_sel), 64'h0);
    cycle();
    issue_valid = 1; issue_rd = 0; issue_lat = 3;
    cycle();
    issue_valid = 0;
    #1 chk("x0_issue_busy", 64'(sb_busy), 64'd0);
    cycle();

    // Load-use
    id_ex_memread = 1; id_ex_rd = 7; if_id_rs = {5'd7, 5'd0};
    #1 chk("loaduse_stall", 64'(stall), 64'd1);
    chk("loaduse_cnt_before", 64'(stall_cycles), 64'd0);
    cycle();
    id_ex_memread = 0; if_id_rs = 0;
    #1 chk("loaduse_cnt_after", 64'(stall_cycles), 64'd1);
    cycle();

    // Latency: visible for exactly 3 cycles after the accept edge
    issue_valid = 1; issue_rd = 9; issue_lat = 3; if_id_rs = {5'd0, 5'd9};
    #1 chk("lat_pre", 64'(stall), 64'd0);
    cycle();
    issue_valid = 0;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("lat_stall_%0d", k), 64'(stall), 64'(k < 3));
      cycle();
    end
    #1 chk("lat_cnt", 64'(stall_cycles), 64'd4);

    // Full / reuse
    for (int k = 0; k < SB_DEPTH; k++) begin
      issue_valid = 1; issue_rd = REG_AW'(10 + k); issue_lat = 4;
      cycle();
    end
    issue_rd = 14; issue_lat = 2;
    #1 chk("full_ready", 64'(issue_ready), 64'd0);
    cycle();
    #1 chk("reuse_ready", 64'(issue_ready), 64'd1);
    chk("reuse_busy", 64'(sb_busy), 64'd1);
    cycle();
    issue_valid = 0;
    for (int k = 0; k < 6; k++) cycle();
    #1 chk("drained_busy", 64'(sb_busy), 64'd0);

    // Reset mid-flight
    issue_valid = 1; issue_rd = 3; issue_lat = 7;
    cycle();
    issue_rd = 4;
    cycle();
    issue_valid = 0; if_id_rs = {5'd4, 5'd3};
    cycle();
    cycle();
    #2 rst = 1'b1;
    model_reset();
    #1 chk("midrst_busy", 64'(sb_busy), 64'd0);
    chk("midrst_ready", 64'(issue_ready), 64'd1);
    chk("midrst_stall_cycles", 64'(stall_cycles), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      ex_mem_regwrite = 1'($urandom_range(0, 1));
      ex_mem_rd       = REG_AW'($urandom_range(0, 7));
      mem_wb_regwrite = 1'($urandom_range(0, 1));
      mem_wb_rd       = REG_AW'($urandom_range(0, 7));
      for (int i = 0; i < NUM_SRC; i++) begin
        id_ex_rs[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
        if_id_rs[i*REG_AW +: REG_AW] = REG_AW'(($urandom_range(0, 9) == 0) ?
                                        $urandom_range(0, 31) : $urandom_range(0, 7));
      end
      id_ex_memread = ($urandom_range(0, 9) < 3);
      id_ex_rd      = REG_AW'($urandom_range(0, 7));
      issue_valid   = 1'($urandom_range(0, 1));
      issue_rd      = REG_AW'($urandom_range(0, 7));
      issue_lat     = LAT_W'($urandom_range(0, 7));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-index width.
REQ-002 The block SHALL have parameter NUM_SRC, default 2, meaning number of source operands per instruction.
REQ-003 The block SHALL have parameter SB_DEPTH, default 4, meaning number of scoreboard entries for in-flight long-latency writes.
REQ-004 The block SHALL have parameter LAT_W, default 3, meaning latency field width.
REQ-005 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_mem_regwrite  in  1  EX/MEM writes a register.
- ex_mem_rd  in  REG_AW  EX/MEM destination.
- mem_wb_regwrite  in  1  MEM/WB writes a register.
- mem_wb_rd  in  REG_AW  MEM/WB destination.
- id_ex_rs  in  NUM_SRC*REG_AW  EX-stage sources; source i occupies bits [i*REG_AW +: REG_AW].
- if_id_rs  in  NUM_SRC*REG_AW  ID-stage sources, packed the same way.
- id_ex_memread  in  1  EX-stage instruction is a load.
- id_ex_rd  in  REG_AW  EX-stage destination.
- issue_valid  in  1  a long-latency op requests issue.
- issue_rd  in  REG_AW  its destination.
- issue_lat  in  LAT_W  its latency in cycles.
- issue_ready  out  1  a free scoreboard entry exists.
- forward_sel  out  2*NUM_SRC  per-source forward select; source i occupies bits [2i+1:2i].
- stall  out  1  hold IF/ID and insert an ID/EX bubble.
- sb_busy  out  1  at least one scoreboard entry is valid.
- stall_cycles  out  32  count of stalled cycles.

Function
REQ-006 forward_sel[i] SHALL be 10 when ex_mem_regwrite=1, ex_mem_rd!=0 and ex_mem_rd==id_ex_rs[i]; else 01 when mem_wb_regwrite=1, mem_wb_rd!=0 and mem_wb_rd==id_ex_rs[i]; else 00 (combinational; EX/MEM has priority).
REQ-007 Load-use hazard for source i SHALL be id_ex_memread=1, id_ex_rd!=0 and id_ex_rd==if_id_rs[i].
REQ-008 Scoreboard hazard for source i SHALL be any valid entry whose rd equals if_id_rs[i], with if_id_rs[i]!=0.
REQ-009 stall SHALL be the combinational OR of all load-use and scoreboard hazards over all sources.
REQ-010 issue_ready SHALL be 1 iff at least one entry is invalid, computed from registered state only.
REQ-011 An issue SHALL be accepted on a rising edge when issue_valid=1 and issue_ready=1. Acceptance allocates the lowest-index invalid entry and sets valid=1, rd=issue_rd and count=issue_lat, with issue_lat=0 treated as 1.
REQ-012 An accepted issue with issue_rd=0 SHALL allocate nothing and SHALL have no effect.
REQ-013 On each edge, every valid entry SHALL decrement its count. An entry with count==1 SHALL be cleared on that edge, so the entry is visible for exactly L cycles after the accept edge.
REQ-014 An entry freed on an edge SHALL NOT be allocated on that same edge. Allocation and decrement SHALL apply to different entries on the same edge without interference.
REQ-015 When issue_valid=1 and issue_ready=0, the request SHALL be ignored with no state change; the requester holds the request.
REQ-016 Duplicate rd values SHALL occupy separate entries, and the hazard SHALL persist until the last matching entry clears.
REQ-017 stall_cycles SHALL increment on each edge where stall=1, saturating at 32'hFFFF_FFFF.
REQ-018 sb_busy SHALL be the OR of all entry valid bits.

Reset
REQ-019 While rst=1, all entries SHALL be invalid with count=0 and stall_cycles SHALL be 0, taking effect immediately (asynchronous).
REQ-020 Consequently, during reset issue_ready=1, sb_busy=0, and stall depends only on the load-use hazard. forward_sel remains combinational from its inputs.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight entries. No completion is signalled.

Structure
REQ-022 Package hazard_pkg SHALL hold the FWD_NONE=2'b00, FWD_WB=2'b01 and FWD_MEM=2'b10 constants, plus the scoreboard entry typedef {valid, rd, count}.
REQ-023 The entry table (allocation, countdown, match vector) SHALL be one sub-module, sb_table; forwarding and stall logic stay in fwd_hazard_unit.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Forward priority: ex_mem_rd=5 and mem_wb_rd=5 (both regwrite=1), id_ex_rs[0]=5 -> forward_sel[1:0]=10. Then ex_mem_regwrite=0 -> 01.
- x0 handling: ex_mem_rd=0 with id_ex_rs=0 -> forward_sel=00. Issue with rd=0 -> sb_busy stays 0.
- Load-use: id_ex_memread=1, id_ex_rd=7, if_id_rs[1]=7 -> stall=1 that cycle; stall_cycles +1.
- Latency: issue rd=9, lat=3, if_id_rs[0]=9 held -> stall=1 for exactly 3 cycles after the accept edge, then 0.
- Full/reuse: SB_DEPTH issues of lat=4 -> issue_ready=0. An extra request is ignored. When the first entry clears, issue_ready=1 on the next cycle.
- Reset mid-flight: assert rst with 2 entries valid -> sb_busy=0, issue_ready=1 and stall_cycles=0 immediately.
